// File: rtl/uart_pkg.sv
// Shared definitions for the UART RX buffer sequencer.
package uart_pkg;

  // Default word width, matching the RX buffer's out_data.
  localparam int DATA_W_DEF = 8;

  // Sequencer states: wait for a word, hold a word for a reader, grant it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FULL  = 2'd1,
    GRANT = 2'd2
  } rx_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at the requester
// just after last_ptr, so the most recent winner has the lowest priority.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] last_ptr,
  output logic [N_REQ-1:0] winner,
  output logic             any_req
);

  logic [PTR_W-1:0] w_idx;

  // Scan from the lowest priority up to the highest, so the last hit is the winner.
  always_comb begin
    winner  = '0;
    any_req = |req;
    w_idx   = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      w_idx = PTR_W'((int'(last_ptr) + off) % N_REQ);
      if (req[w_idx]) begin
        winner        = '0;
        winner[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_buffer_ctrl.sv
// Sequencer for the one-word UART RX buffer: loads receiver words,
// hands the held word to one of N_REQ readers in round-robin order, and
// keeps sticky overrun / frame-error status.
module rx_buffer_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_REQ  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_done_tick,
  input  logic              rx_frame_err,
  input  logic              rx_empty,
  input  logic [DATA_W-1:0] buf_data,
  output logic              set_flag,
  output logic              clear_flag,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              overrun,
  output logic              frame_err,
  input  logic              err_clear
);

  localparam int PTR_W = $clog2(N_REQ);

  rx_state_t         r_state, w_state_next;
  logic              r_set_flag, r_pend_set, r_clear_flag, r_rd_valid;
  logic [N_REQ-1:0]  r_gnt, w_gnt_next;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_overrun, r_frame_err;
  logic [PTR_W-1:0]  r_last_ptr, w_win_idx;
  logic [N_REQ-1:0]  w_winner;
  logic              w_any_req, w_clear_next, w_rd_valid_next;
  logic              w_buf_free, w_accept, w_drop, w_bad, w_set_due;

  rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
    .req      (req),
    .last_ptr (r_last_ptr),
    .winner   (w_winner),
    .any_req  (w_any_req)
  );

  // The buffer counts as free when empty or when it is being cleared this
  // cycle; a set already on its way means the slot is spoken for.
  assign w_buf_free = (rx_empty || r_clear_flag) && !r_set_flag && !r_pend_set;
  assign w_bad      = rx_done_tick && rx_frame_err;
  assign w_accept   = rx_done_tick && !rx_frame_err && w_buf_free;
  assign w_drop     = rx_done_tick && !rx_frame_err && !w_buf_free;
  assign w_set_due  = w_accept || r_pend_set;

  // Convert the one-hot winner to an index for the round-robin pointer.
  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_winner[i]) w_win_idx = PTR_W'(i);
    end
  end

  // Next-state and next-output logic of the read sequencer.
  always_comb begin
    w_state_next    = r_state;
    w_gnt_next      = '0;
    w_rd_valid_next = 1'b0;
    w_clear_next    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rx_empty) w_state_next = FULL;
      end
      FULL: begin
        // An external clear empties the buffer: nothing left to grant.
        if (rx_empty) begin
          w_state_next = IDLE;
        end else if (w_any_req) begin
          w_state_next    = GRANT;
          w_gnt_next      = w_winner;
          w_rd_valid_next = 1'b1;
          w_clear_next    = 1'b1;
        end
      end
      GRANT:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State, grant outputs, delivered word and round-robin pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_gnt        <= '0;
      r_rd_valid   <= 1'b0;
      r_clear_flag <= 1'b0;
      r_rd_data    <= '0;
      r_last_ptr   <= PTR_W'(N_REQ - 1);
    end else begin
      r_state      <= w_state_next;
      r_gnt        <= w_gnt_next;
      r_rd_valid   <= w_rd_valid_next;
      r_clear_flag <= w_clear_next;
      if (w_rd_valid_next) begin
        r_rd_data  <= buf_data;
        r_last_ptr <= w_win_idx;
      end
    end
  end

  // Issue set_flag, deferring it one cycle when it would coincide with a clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_set_flag <= 1'b0;
      r_pend_set <= 1'b0;
    end else begin
      r_set_flag <= w_set_due && !w_clear_next;
      r_pend_set <= w_set_due && w_clear_next;
    end
  end

  // Sticky status; a fresh error outranks a simultaneous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_drop)         r_overrun <= 1'b1;
      else if (err_clear) r_overrun <= 1'b0;
      if (w_bad)          r_frame_err <= 1'b1;
      else if (err_clear) r_frame_err <= 1'b0;
    end
  end

  assign set_flag   = r_set_flag;
  assign clear_flag = r_clear_flag;
  assign gnt        = r_gnt;
  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;
  assign overrun    = r_overrun;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_rx_buffer_ctrl.sv
// Directed bench for rx_buffer_ctrl with a behavioural one-word RX buffer.
module tb_rx_buffer_ctrl;

  logic       clock;
  logic       reset;
  logic       rx_done_tick;
  logic       rx_frame_err;
  logic       rx_empty;
  logic [7:0] buf_data;
  logic       set_flag;
  logic       clear_flag;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       overrun;
  logic       frame_err;
  logic       err_clear;
  logic [7:0] rx_word;

  int n_tests = 0;
  int n_fail  = 0;

  rx_buffer_ctrl #(.DATA_W(8), .N_REQ(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_frame_err (rx_frame_err),
    .rx_empty     (rx_empty),
    .buf_data     (buf_data),
    .set_flag     (set_flag),
    .clear_flag   (clear_flag),
    .req          (req),
    .gnt          (gnt),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .overrun      (overrun),
    .frame_err    (frame_err),
    .err_clear    (err_clear)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  // One-word buffer: clear has priority over set.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_empty <= 1'b1;
      buf_data <= 8'h00;
    end else if (clear_flag) begin
      rx_empty <= 1'b1;
    end else if (set_flag) begin
      rx_empty <= 1'b0;
      buf_data <= rx_word;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_tick(input logic [7:0] d, input logic fe);
    rx_word      = d;
    rx_frame_err = fe;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    rx_frame_err = 1'b0;
  endtask

  task automatic wait_grant(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (rd_valid) break;
      step();
    end
    check_val({tag, "_seen"}, 32'(rd_valid), 32'd1);
  endtask

  task automatic deliver(input logic [7:0] d, input logic [1:0] exp_g, input string tag);
    send_tick(d, 1'b0);
    wait_grant(tag);
    check_val({tag, "_gnt"}, 32'(gnt), 32'(exp_g));
    check_val({tag, "_data"}, 32'(rd_data), 32'(d));
    step();
  endtask

  initial begin
    reset        = 1'b0;
    rx_done_tick = 1'b0;
    rx_frame_err = 1'b0;
    req          = 2'b00;
    err_clear    = 1'b0;
    rx_word      = 8'h00;
    repeat (3) step();
    check_val("rst_ctrl", 32'({set_flag, clear_flag, gnt, rd_valid, overrun, frame_err}), 32'd0);
    check_val("rst_data", 32'(rd_data), 32'd0);
    reset = 1'b1;
    step();

    // Single word with exact latency, then reset asserted mid-grant.
    req = 2'b10;
    send_tick(8'hA5, 1'b0);
    check_val("single_set", 32'(set_flag), 32'd1);
    step();
    check_val("single_set_pulse", 32'(set_flag), 32'd0);
    step();
    step();
    check_val("single_gnt", 32'(gnt), 32'h2);
    check_val("single_valid", 32'(rd_valid), 32'd1);
    check_val("single_data", 32'(rd_data), 32'hA5);
    check_val("single_clear", 32'(clear_flag), 32'd1);
    reset = 1'b0;
    #2;
    check_val("midrst_outs", 32'({gnt, rd_valid, clear_flag}), 32'd0);
    check_val("midrst_data", 32'(rd_data), 32'd0);
    req = 2'b00;
    step();
    reset = 1'b1;
    step();
    check_val("midrst_state", 32'(dut.r_state), 32'd0);

    // Round-robin with both requesters held.
    req = 2'b11;
    deliver(8'h11, 2'b01, "rr1");
    deliver(8'h22, 2'b10, "rr2");
    deliver(8'h33, 2'b01, "rr3");

    // Overrun: second word dropped while the first is unread.
    req = 2'b00;
    check_val("ovr_init", 32'(overrun), 32'd0);
    send_tick(8'h41, 1'b0);
    repeat (3) step();
    check_val("ovr_full", 32'(rx_empty), 32'd0);
    send_tick(8'h42, 1'b0);
    check_val("ovr_flag", 32'(overrun), 32'd1);
    check_val("ovr_noset", 32'(set_flag), 32'd0);
    req = 2'b01;
    wait_grant("ovr_rd");
    check_val("ovr_rd_gnt", 32'(gnt), 32'h1);
    check_val("ovr_rd_data", 32'(rd_data), 32'h41);
    req = 2'b00;
    step();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check_val("ovr_cleared", 32'(overrun), 32'd0);

    // Collision: new tick during the grant/clear cycle.
    req = 2'b10;
    send_tick(8'h55, 1'b0);
    wait_grant("col1");
    check_val("col1_clear", 32'(clear_flag), 32'd1);
    check_val("col1_noset", 32'(set_flag), 32'd0);
    check_val("col1_data", 32'(rd_data), 32'h55);
    send_tick(8'h66, 1'b0);
    check_val("col_set_next", 32'(set_flag), 32'd1);
    check_val("col_clear_low", 32'(clear_flag), 32'd0);
    step();
    check_val("col_ovr", 32'(overrun), 32'd0);
    wait_grant("col2");
    check_val("col2_gnt", 32'(gnt), 32'h2);
    check_val("col2_data", 32'(rd_data), 32'h66);
    req = 2'b00;
    step();

    // Frame error: word rejected, sticky flag, error beats clear.
    check_val("ferr_init", 32'(frame_err), 32'd0);
    send_tick(8'h77, 1'b1);
    check_val("ferr_noset", 32'(set_flag), 32'd0);
    check_val("ferr_flag", 32'(frame_err), 32'd1);
    step();
    check_val("ferr_empty", 32'(rx_empty), 32'd1);
    check_val("ferr_noset2", 32'(set_flag), 32'd0);
    err_clear = 1'b1;
    send_tick(8'h78, 1'b1);
    err_clear = 1'b0;
    check_val("ferr_err_wins", 32'(frame_err), 32'd1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check_val("ferr_cleared", 32'(frame_err), 32'd0);
    check_val("ferr_ovr", 32'(overrun), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
